uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//   8N1 UART receiver that turns the serial pin input into whole bytes for control_module.
//   It runs entirely in clk_in, the 53.20 MHz root oscillator domain.
//   The line is idle-high and frames are LSB first; bytes go out as a 1-cycle data_valid strobe.
//   rx_running marks frame activity and feeds the control module's receive timeout logic.
// PARAMETERS
//   CLK_PER_BIT   462  clk_in cycles per bit (53.2 MHz / 115200). Legal range 4..2^COUNT_WIDTH-1.
//   COUNT_WIDTH   10   width of the bit-timing counter.
// PORTS
//   clk_in         input   1  root clock; all logic is on its rising edge
//   reset          input   1  synchronous, active-high reset
//   uart_rx        input   1  raw asynchronous serial line; idle = 1
//   data           output  8  last good received byte; held until the next good byte
//   data_valid     output  1  1-cycle strobe: data has just been updated
//   framing_error  output  1  1-cycle strobe: stop bit sampled as 0
//   rx_running     output  1  high while a frame is in progress or a break persists
// BEHAVIOUR
//   - Reset values, all applied on the clk_in edge while reset=1:
//     data=8'h00, data_valid=0, framing_error=0, rx_running=0, state=IDLE.
//     Both synchronizer flops = 1, counter = 0, bit index = 0.
//   - Synchronizer: uart_rx passes through 2 flops, giving rx_s. An edge detect uses one further flop (rx_d).
//   - HALF = CLK_PER_BIT/2, truncating integer division. The counter counts 0..N-1.
//   - States:
//     IDLE: on rx_d=1 and rx_s=0, clear the counter and go to START.
//     START: after HALF cycles, sample rx_s.
//       If 0, go to DATA with bit index 0 and counter cleared.
//       If 1, the start bit was a glitch: return to IDLE with no strobe.
//     DATA: every CLK_PER_BIT cycles, sample rx_s into the shift register (shift right, MSB in).
//       After the 8th sample, go to STOP.
//     STOP: after CLK_PER_BIT cycles, sample rx_s.
//       If 1: data <= shift register, data_valid=1 for the next cycle, go to IDLE.
//       If 0: framing_error=1 for the next cycle, data is unchanged, go to BREAK.
//     BREAK: wait until rx_s=1, then go to IDLE. This keeps a held-low line from re-triggering.
//   - rx_running = (state != IDLE). It is registered and goes high the cycle after the falling edge is seen.
//   - Sample instants, measured from the edge-detect cycle: HALF + k*CLK_PER_BIT.
//     k=0 is the start bit, k=1..8 are the data bits, k=9 is the stop bit.
//     data_valid is high in the cycle after the k=9 sample.
//   - A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back frames need no idle gap.
//   - data_valid and framing_error are never high together. Each is high for exactly one cycle.
//   - Reset mid-frame abandons the frame: no strobes, and data returns to 0.
//   - No FIFO. The consumer must accept data within 1 frame time, or the next byte overwrites it.
// TESTING  (CLK_PER_BIT=8 unless noted)
//   1. Reset, then send 0x55 with an 8-cycle bit period.
//      -> data=0x55, one data_valid pulse, rx_running high from edge to the stop sample, framing_error=0.
//   2. Send 0xA3 then 0x0F back-to-back with no idle bits.
//      -> two data_valid pulses, 10 bit-times apart, with data 0xA3 then 0x0F.
//   3. Pull uart_rx low for 3 cycles, then high.
//      -> rx_running pulses high for about HALF cycles, then returns to IDLE; no strobes.
//   4. Send 0x00 with the stop bit low, then hold the line low for 40 cycles, then high.
//      -> one framing_error pulse; data keeps the previous value.
//      -> rx_running stays high until the line returns high, and no second frame starts.
//   5. Assert reset during data bit 4 of 0x3C.
//      -> all outputs 0 on the next cycle, and no strobe is produced.
//      -> a following 0xC6 is received correctly.
//   6. With CLK_PER_BIT=64, send 0x96 at bit periods of 61 and then 67 cycles.
//      -> data=0x96 each time with no framing_error (about ±4.7% baud tolerance).

Source files
------------

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver running entirely in the clk_in domain. The idle-high
//   serial line is synchronized, a falling edge starts a frame, and every bit
//   is sampled at its nominal centre (LSB first). A good frame updates data
//   and produces a one-cycle data_valid strobe. A low stop bit produces a
//   one-cycle framing_error strobe instead, and the receiver then waits for
//   the line to return high before it looks for another start edge.
//
// Ports
//   clk_in         in   1  root clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   uart_rx        in   1  asynchronous serial line, idle = 1
//   data           out  8  last good byte, held until the next good byte
//   data_valid     out  1  one-cycle strobe: data has just been updated
//   framing_error  out  1  one-cycle strobe: stop bit sampled as 0
//   rx_running     out  1  high while a frame or a line break is in progress
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_PER_BIT = 462,
  parameter int COUNT_WIDTH = 10
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       rx_running
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Terminal counts: the counter runs 0..N-1, so a wait of N cycles ends at N-1.
  localparam logic [COUNT_WIDTH-1:0] LP_HALF_LAST = COUNT_WIDTH'(CLK_PER_BIT / 2 - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_BIT_LAST  = COUNT_WIDTH'(CLK_PER_BIT - 1);

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_rx_s;
  logic                   r_rx_d;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_data_valid;
  logic                   r_framing_error;
  logic                   r_rx_running;

  state_t                 w_state_nxt;
  logic [COUNT_WIDTH-1:0] w_cnt_nxt;
  logic [2:0]             w_bit_idx_nxt;
  logic [7:0]             w_shift_nxt;
  logic [7:0]             w_data_nxt;
  logic                   w_data_valid_nxt;
  logic                   w_framing_error_nxt;

  // Two-flop synchronizer for the raw line plus one delay flop for edge detect.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  // State, bit timing and output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_data          <= 8'h00;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_rx_running    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_data          <= w_data_nxt;
      r_data_valid    <= w_data_valid_nxt;
      r_framing_error <= w_framing_error_nxt;
      // Registered from the next state so it tracks state != IDLE with no lag.
      r_rx_running    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state logic: frame sequencing and centre-of-bit sampling.
  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt + COUNT_WIDTH'(1);
    w_bit_idx_nxt       = r_bit_idx;
    w_shift_nxt         = r_shift;
    w_data_nxt          = r_data;
    w_data_valid_nxt    = 1'b0;
    w_framing_error_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_d && !r_rx_s) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_START: begin
        if (r_cnt == LP_HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = 3'd0;
          // A start bit that is already high again at its centre is a glitch.
          if (!r_rx_s) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_START;
        end
      end

      ST_DATA: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_rx_s, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_STOP: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_data_nxt       = r_shift;
            w_data_valid_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_framing_error_nxt = 1'b1;
            w_state_nxt         = ST_BREAK;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end

      ST_BREAK: begin
        // Hold off until the line is released so a stuck-low line cannot retrigger.
        w_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BREAK;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign rx_running    = r_rx_running;

endmodule
